// File: rtl/qpsk_link_stream.sv
// qpsk_link_stream: clocked QPSK modem loopback model.
//   Accepts a DATA_W-bit word (in_valid/in_ready), emits it as DATA_W/2 QPSK
//   symbols (MSB pair first, one per clock) on i_sym/q_sym/sym_valid, adds
//   noise_i/noise_q with saturation, delays by CHAN_LAT registers, slices on
//   sign and reassembles the word on out_data (out_valid/out_ready).
//   busy is high whenever a word is in flight.
// Optional: define QPSK_LINK_ERRCNT_EN to add err_cnt[15:0], a saturating
//   count of output words that differ from the transmitted word.
// Clock: clk rising edge. Reset: rst_n asynchronous, active low.
module qpsk_link_stream #(
  parameter int unsigned DATA_W   = 20,
  parameter int unsigned IQ_W     = 11,
  parameter int          AMP      = 511,
  parameter int unsigned CHAN_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IQ_W-1:0]   noise_i,
  input  logic [IQ_W-1:0]   noise_q,
  output logic [IQ_W-1:0]   i_sym,
  output logic [IQ_W-1:0]   q_sym,
  output logic              sym_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef QPSK_LINK_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int unsigned N = DATA_W / 2;
  localparam logic [IQ_W-1:0] AMP_P = IQ_W'(AMP);
  localparam logic [IQ_W-1:0] AMP_N = IQ_W'(-AMP);

  typedef enum logic [1:0] {IDLE, TX, DRAIN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [IQ_W-1:0]   i_sym_q, i_sym_d, q_sym_q, q_sym_d;
  logic              sym_valid_q, sym_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [IQ_W-1:0]   chan_i, chan_q;
  logic              chan_vld;
  logic [IQ_W-1:0]   slice_i, slice_q;
  logic              slice_vld;

  function automatic logic [IQ_W-1:0] sat_add(input logic [IQ_W-1:0] a,
                                              input logic [IQ_W-1:0] b);
    logic [IQ_W:0] s;
    s = {a[IQ_W-1], a} + {b[IQ_W-1], b};
    if (s[IQ_W] != s[IQ_W-1])
      sat_add = s[IQ_W] ? {1'b1, {(IQ_W-1){1'b0}}} : {1'b0, {(IQ_W-1){1'b1}}};
    else
      sat_add = s[IQ_W-1:0];
  endfunction

  // Idle channel slots carry zero so noise never reaches the slicer.
  always_comb begin
    chan_vld = sym_valid_q;
    chan_i   = sym_valid_q ? sat_add(i_sym_q, noise_i) : '0;
    chan_q   = sym_valid_q ? sat_add(q_sym_q, noise_q) : '0;
  end

  generate
    if (CHAN_LAT == 0) begin : g_nolat
      assign slice_i   = chan_i;
      assign slice_q   = chan_q;
      assign slice_vld = chan_vld;
    end else begin : g_lat
      logic [CHAN_LAT-1:0][IQ_W-1:0] dly_i_q, dly_i_d, dly_q_q, dly_q_d;
      logic [CHAN_LAT-1:0]           dly_v_q, dly_v_d;

      always_comb begin
        dly_i_d    = dly_i_q;
        dly_q_d    = dly_q_q;
        dly_v_d    = dly_v_q;
        dly_i_d[0] = chan_i;
        dly_q_d[0] = chan_q;
        dly_v_d[0] = chan_vld;
        for (int unsigned s = 1; s < CHAN_LAT; s++) begin
          dly_i_d[s] = dly_i_q[s-1];
          dly_q_d[s] = dly_q_q[s-1];
          dly_v_d[s] = dly_v_q[s-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_i_q <= '0;
          dly_q_q <= '0;
          dly_v_q <= '0;
        end else begin
          dly_i_q <= dly_i_d;
          dly_q_q <= dly_q_d;
          dly_v_q <= dly_v_d;
        end
      end

      assign slice_i   = dly_i_q[CHAN_LAT-1];
      assign slice_q   = dly_q_q[CHAN_LAT-1];
      assign slice_vld = dly_v_q[CHAN_LAT-1];
    end
  endgenerate

`ifdef QPSK_LINK_ERRCNT_EN
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    i_sym_d     = i_sym_q;
    q_sym_d     = q_sym_q;
    sym_valid_d = sym_valid_q;
    out_data_d  = out_data_q;
`ifdef QPSK_LINK_ERRCNT_EN
    tx_word_d   = tx_word_q;
    err_cnt_d   = err_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Symbol 0 is loaded on the accepting edge; word_q keeps the rest.
          i_sym_d     = in_data[DATA_W-1] ? AMP_N : AMP_P;
          q_sym_d     = in_data[DATA_W-2] ? AMP_N : AMP_P;
          sym_valid_d = 1'b1;
          word_d      = in_data << 2;
          cnt_d       = 7'd1;
          state_d     = TX;
`ifdef QPSK_LINK_ERRCNT_EN
          tx_word_d   = in_data;
`endif
        end
      end
      TX: begin
        if (cnt_q == 7'(N)) begin
          i_sym_d     = '0;
          q_sym_d     = '0;
          sym_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = (CHAN_LAT == 0) ? HOLD : DRAIN;
        end else begin
          i_sym_d = word_q[DATA_W-1] ? AMP_N : AMP_P;
          q_sym_d = word_q[DATA_W-2] ? AMP_N : AMP_P;
          word_d  = word_q << 2;
          cnt_d   = cnt_q + 7'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == 7'(CHAN_LAT - 1)) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef QPSK_LINK_ERRCNT_EN
          if ((out_data_q != tx_word_q) && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Sliced pairs enter at the LSB end so the first pair ends up on top.
    if (slice_vld)
      out_data_d = (out_data_q << 2) |
                   DATA_W'({slice_i[IQ_W-1], slice_q[IQ_W-1]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      cnt_q       <= '0;
      i_sym_q     <= '0;
      q_sym_q     <= '0;
      sym_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef QPSK_LINK_ERRCNT_EN
      tx_word_q   <= '0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      i_sym_q     <= i_sym_d;
      q_sym_q     <= q_sym_d;
      sym_valid_q <= sym_valid_d;
      out_data_q  <= out_data_d;
`ifdef QPSK_LINK_ERRCNT_EN
      tx_word_q   <= tx_word_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign i_sym     = i_sym_q;
  assign q_sym     = q_sym_q;
  assign sym_valid = sym_valid_q;
  assign out_data  = out_data_q;
`ifdef QPSK_LINK_ERRCNT_EN
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_qpsk_link_stream.sv
// Testbench for qpsk_link_stream: default configuration plus a DATA_W=8,
// CHAN_LAT=0 instance. Expected words come from a per-symbol arithmetic model.
module tb_qpsk_link_stream;

  localparam int N   = 10;
  localparam int L   = 2;
  localparam int AMP = 511;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] noise_i = '0, noise_q = '0;
  logic [10:0] i_sym, q_sym;
  logic        sym_valid;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  logic [7:0]  s_in_data = '0;
  logic        s_in_valid = 1'b0, s_in_ready;
  logic [10:0] s_noise_i = '0, s_noise_q = '0;
  logic [10:0] s_i_sym, s_q_sym;
  logic        s_sym_valid, s_out_valid, s_busy;
  logic [7:0]  s_out_data;
  logic        s_out_ready = 1'b0;

`ifdef QPSK_LINK_ERRCNT_EN
  logic [15:0] err_cnt, s_err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  qpsk_link_stream #(.DATA_W(20), .IQ_W(11), .AMP(511), .CHAN_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .noise_i(noise_i), .noise_q(noise_q),
    .i_sym(i_sym), .q_sym(q_sym), .sym_valid(sym_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
`ifdef QPSK_LINK_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  qpsk_link_stream #(.DATA_W(8), .IQ_W(11), .AMP(511), .CHAN_LAT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .noise_i(s_noise_i), .noise_q(s_noise_q),
    .i_sym(s_i_sym), .q_sym(s_q_sym), .sym_valid(s_sym_valid),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .busy(s_busy)
`ifdef QPSK_LINK_ERRCNT_EN
    , .err_cnt(s_err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sym_val(input bit b);
    return b ? -AMP : AMP;
  endfunction

  function automatic int clamp(input int v);
    if (v > 1023) return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  function automatic logic [19:0] model(input logic [19:0] w, input int ni[10], input int nq[10]);
    logic [19:0] r = '0;
    for (int k = 0; k < N; k++) begin
      int yi = clamp(sym_val(w[19-2*k]) + ni[k]);
      int yq = clamp(sym_val(w[18-2*k]) + nq[k]);
      r = {r[17:0], (yi < 0), (yq < 0)};
    end
    return r;
  endfunction

  task automatic run_word(input logic [19:0] w, input int ni[10], input int nq[10],
                          input int bp, input logic [19:0] nxt, input bit nxt_v,
                          input bit expect_now);
    int waited = 0;
    int cyc_valid = 0;
    logic [19:0] exp, held;
    logic [10:0] ei, eq;
    exp = model(w, ni, nq);
    in_data = w;
    in_valid = 1'b1;
    out_ready = (bp == 0);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_idle", in_ready, 1);
    if (expect_now) check("accept_next_cycle", waited, 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_data = nxt;
        in_valid = nxt_v;
      end
      check("sym_valid", sym_valid, (c <= N));
      check("in_ready_busy", in_ready, 0);
      check("busy", busy, 1);
      if (c <= N) begin
        ei = 11'(sym_val(w[19-2*(c-1)]));
        eq = 11'(sym_val(w[18-2*(c-1)]));
        check("i_sym", i_sym, ei);
        check("q_sym", q_sym, eq);
        noise_i = 11'(ni[c-1]);
        noise_q = 11'(nq[c-1]);
      end else begin
        noise_i = 11'($urandom);
        noise_q = 11'($urandom);
      end
      if (out_valid) begin
        cyc_valid = c;
        break;
      end
    end
    check("out_valid_cycle", cyc_valid, N + L + 1);
    check("out_data", out_data, exp);
    held = out_data;
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, held);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    noise_i = '0;
    noise_q = '0;
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);
    check("post_out_data", out_data, exp);
`ifdef QPSK_LINK_ERRCNT_EN
    if (exp != w) exp_err++;
    check("err_cnt", err_cnt, exp_err);
`endif
  endtask

  initial begin
    int z[10];
    int ni[10];
    int nq[10];
    int cyc;
    logic [19:0] w2;
    foreach (z[k]) z[k] = 0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_i_sym", i_sym, 0);
    check("rst_q_sym", q_sym, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
`ifdef QPSK_LINK_ERRCNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_word(20'hA5F3C, z, z, 0, 20'h0, 1'b0, 1'b0);

    // Noise margin on symbol 0 of an all-zero word.
    ni = z; ni[0] = 600;
    run_word(20'h00000, ni, z, 0, 20'h0, 1'b0, 1'b0);
    ni[0] = -511;
    run_word(20'h00000, ni, z, 0, 20'h0, 1'b0, 1'b0);
    ni[0] = -512;
    check("margin_model", model(20'h00000, ni, z), 20'h80000);
    run_word(20'h00000, ni, z, 0, 20'h0, 1'b0, 1'b0);

    // Saturation.
    foreach (ni[k]) begin ni[k] = -1024; nq[k] = -1024; end
    run_word(20'hFFFFF, ni, nq, 0, 20'h0, 1'b0, 1'b0);

    // Backpressure with a second word waiting.
    w2 = 20'h3C5A1;
    run_word(20'h5A5A5, z, z, 7, w2, 1'b1, 1'b0);
    run_word(w2, z, z, 0, 20'h0, 1'b0, 1'b1);

    // Random words and noise.
    for (int t = 0; t < 10; t++) begin
      foreach (ni[k]) begin
        ni[k] = int'($urandom_range(0, 1400)) - 700;
        nq[k] = int'($urandom_range(0, 1400)) - 700;
      end
      run_word(20'($urandom), ni, nq, int'($urandom_range(0, 3)), 20'h0, 1'b0, 1'b0);
    end

    // Reset in the middle of TX.
    in_data = 20'hFEDCB;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sym_valid", sym_valid, 0);
    check("mid_rst_i_sym", i_sym, 0);
    check("mid_rst_q_sym", q_sym, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_word(20'h12345, z, z, 0, 20'h0, 1'b0, 1'b0);

    // DATA_W=8, CHAN_LAT=0 instance.
    s_in_data = 8'hC6;
    s_in_valid = 1'b1;
    s_out_ready = 1'b1;
    check("s_in_ready", s_in_ready, 1);
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        s_in_valid = 1'b0;
        check("s_i_sym0", s_i_sym, 11'h601);
        check("s_q_sym0", s_q_sym, 11'h601);
      end
      check("s_sym_valid", s_sym_valid, (c <= 4));
      if (s_out_valid) begin
        cyc = c;
        break;
      end
    end
    check("s_out_valid_cycle", cyc, 5);
    check("s_out_data", s_out_data, 8'hC6);
    @(negedge clk);
    check("s_post_in_ready", s_in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
